// File: rtl/qerv_pkg.sv
// Shared state encoding, decode flags and width helpers for the qerv serial sequencer.
// The top and the beat counter both take their beat count from beats_of().
package qerv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_INIT   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_EXEC   = 3'd5
  } state_t;

  // Decoder outputs captured in DECODE and held for the whole instruction.
  typedef struct packed {
    logic two_stage;
    logic mem_op;
    logic jump;
    logic iscomp;
    logic trap_req;
  } flags_t;

  function automatic bit w_legal(input int w);
    return (w == 1) || (w == 4);
  endfunction

  function automatic int beats_of(input int w);
    return 32 / w;
  endfunction

endpackage

// File: rtl/qerv_beat_cnt.sv
// Beat counter for a 32-bit serial pass of W-bit beats, with bit-position strobes.
// Counts while i_en is high, wraps after the last beat, and is held at 0 while i_en is low.
module qerv_beat_cnt
  import qerv_pkg::*;
#(
  parameter int W     = 1,
  parameter int BEATS = beats_of(W)
) (
  input  logic clk,
  input  logic i_rst_n,
  input  logic i_en,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt2,
  output logic o_cnt12to31,
  output logic o_cnt_done
);

  localparam int CW = $clog2(BEATS);
  localparam logic [CW-1:0] LAST = CW'(BEATS - 1);

  logic [CW-1:0] r_cnt;
  logic [5:0]    w_lo;
  logic [5:0]    w_hi;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_cnt <= '0;
    else if (!i_en)
      r_cnt <= '0;
    else if (r_cnt == LAST)
      r_cnt <= '0;
    else
      r_cnt <= r_cnt + 1'b1;
  end

  // Bit range [w_lo, w_hi] of the 32-bit word carried by the current beat.
  assign w_lo = 6'(r_cnt) * 6'(W);
  assign w_hi = w_lo + 6'(W - 1);

  assign o_cnt0      = i_en && (w_lo == 6'd0);
  assign o_cnt1      = i_en && (w_lo <= 6'd1) && (w_hi >= 6'd1);
  assign o_cnt2      = i_en && (w_lo <= 6'd2) && (w_hi >= 6'd2);
  assign o_cnt12to31 = i_en && (w_lo >= 6'd12);
  assign o_cnt_done  = i_en && (r_cnt == LAST);

endmodule

// File: rtl/qerv_seq.sv
// Instruction sequencer for a bit/nibble-serial core: fetch, decode, optional INIT pass, data wait, EXEC pass.
// Fetch-to-fetch is 1 + ibus ack latency + 1 + BEATS cycles for single-pass ops; WAIT stalls on i_dbus_ack.
// Optional QERV_MISALIGN_TRAP_EN: uncompressed jumps get an INIT pass that checks target bit 1 and traps.
module qerv_seq
  import qerv_pkg::*;
#(
  parameter int W     = 1,
  parameter int BEATS = beats_of(W)
) (
  input  logic clk,
  input  logic i_rst_n,
  output logic o_ibus_cyc,
  input  logic i_ibus_ack,
  input  logic i_two_stage,
  input  logic i_mem_op,
  input  logic i_dbus_ack,
  input  logic i_jump,
  input  logic i_iscomp,
  input  logic i_trap_req,
  input  logic i_tgt_bit1,
  output logic o_init,
  output logic o_cnt_en,
  output logic o_pc_en,
  output logic o_trap,
  output logic o_cnt0,
  output logic o_cnt1,
  output logic o_cnt2,
  output logic o_cnt12to31,
  output logic o_cnt_done
);

  if (!w_legal(W)) begin : g_w_check
    $error("qerv_seq: W must be 1 or 4");
  end

  state_t r_state;
  state_t w_next;
  flags_t r_flags;
  logic   r_ibus_cyc;
  logic   w_jump_init;
  logic   w_misalign;
  logic   w_unused;

`ifdef QERV_MISALIGN_TRAP_EN
  logic r_misalign;

  assign w_jump_init = i_jump && !i_iscomp;

  // Target bit 1 is only visible in the beat carrying bit 1 of the INIT pass.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_misalign <= 1'b0;
    else if (r_state == ST_DECODE)
      r_misalign <= 1'b0;
    else if ((r_state == ST_INIT) && o_cnt1 && r_flags.jump && !r_flags.iscomp && i_tgt_bit1)
      r_misalign <= 1'b1;
  end

  assign w_misalign = r_misalign;
  assign w_unused   = r_flags.two_stage;
`else
  assign w_jump_init = 1'b0;
  assign w_misalign  = 1'b0;
  assign w_unused    = ^{i_jump, i_iscomp, i_tgt_bit1,
                         r_flags.two_stage, r_flags.jump, r_flags.iscomp};
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH:  if (i_ibus_ack) w_next = ST_DECODE;
      ST_DECODE: w_next = (i_two_stage || w_jump_init) ? ST_INIT : ST_EXEC;
      ST_INIT:   if (o_cnt_done) w_next = (r_flags.mem_op && !w_misalign) ? ST_WAIT : ST_EXEC;
      ST_WAIT:   if (i_dbus_ack) w_next = ST_EXEC;
      ST_EXEC:   if (o_cnt_done) w_next = ST_FETCH;
      default:   w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    o_init   = 1'b0;
    o_cnt_en = 1'b0;
    o_pc_en  = 1'b0;
    o_trap   = 1'b0;
    case (r_state)
      ST_INIT: begin
        o_init   = 1'b1;
        o_cnt_en = 1'b1;
      end
      ST_EXEC: begin
        o_cnt_en = 1'b1;
        o_pc_en  = 1'b1;
        o_trap   = r_flags.trap_req || w_misalign;
      end
      default: ;
    endcase
  end

  // Fetch request rises with FETCH entry and drops on the acknowledging edge.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_ibus_cyc <= 1'b0;
    else if ((w_next == ST_FETCH) && (r_state != ST_FETCH))
      r_ibus_cyc <= 1'b1;
    else if ((r_state == ST_FETCH) && i_ibus_ack)
      r_ibus_cyc <= 1'b0;
  end

  assign o_ibus_cyc = r_ibus_cyc;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_flags <= '0;
    else if (r_state == ST_DECODE)
      r_flags <= '{two_stage: i_two_stage, mem_op: i_mem_op, jump: i_jump,
                   iscomp: i_iscomp, trap_req: i_trap_req};
  end

  qerv_beat_cnt #(
    .W     (W),
    .BEATS (BEATS)
  ) u_beat_cnt (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_en        (o_cnt_en),
    .o_cnt0      (o_cnt0),
    .o_cnt1      (o_cnt1),
    .o_cnt2      (o_cnt2),
    .o_cnt12to31 (o_cnt12to31),
    .o_cnt_done  (o_cnt_done)
  );

endmodule
